// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fifo_rd_pkg                                                     |
// | Purpose : Shared constants, FSM encoding and helpers for fifo_rd_stream.  |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int BUF_DEPTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Pointer increment that wraps at BUF_DEPTH (not a power of two).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_skid_buf                                                 |
// | Purpose : 3-entry in-order circular buffer between FIFO capture and the   |
// |           output stream.                                                  |
// | Ports   : clk, rst (async active-low)                                     |
// |           push_i / data_i  - write data_i at tail                         |
// |           pop_i            - advance head (ignored when empty)            |
// |           data_o           - head entry                                   |
// |           occ_o            - number of valid entries (0..3)               |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [1:0]        head_q;
  logic [1:0]        tail_q;
  logic [1:0]        occ_q;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = pop_i && (occ_q != 2'd0);
  // A push into a full buffer is only legal when a pop frees the head slot.
  assign w_push = push_i && ((occ_q != 2'(BUF_DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[tail_q] <= data_i;
        tail_q        <= ptr_inc(tail_q);
      end
      if (w_pop) begin
        head_q <= ptr_inc(head_q);
      end
      case ({w_push, w_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign data_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fifo_rd_stream                                                  |
// | Purpose : Reads an upstream FIFO (1-cycle read latency) and presents the  |
// |           bytes as a valid/ready stream, with a delivered-byte counter.   |
// | Ports   : clk, rst (async active-low)                                     |
// |           enable            - permits new FIFO reads                      |
// |           fifo_empty/dout   - upstream FIFO status and read data          |
// |           fifo_rd_en        - upstream read request                       |
// |           m_data/valid/ready- output stream                               |
// |           xfer_cnt          - bytes delivered (wraps)                     |
// |           idle              - FSM in IDLE                                 |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              idle
);

  state_e            state_q;
  state_e            state_d;
  logic              idle_q;
  logic              infl_q;
  logic [CNT_W-1:0]  xfer_cnt_q;
  logic [1:0]        occ;
  logic [2:0]        w_pending;
  logic              w_xfer;
  logic [DATA_W-1:0] w_head;

  // Entries held plus the one still in flight must leave room for a new
  // read, so a read is issued only when at most two slots are spoken for.
  // m_ready is deliberately excluded to keep the FIFO side free of paths
  // from the downstream consumer.
  assign w_pending  = {1'b0, occ} + {2'b00, infl_q};
  assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && (w_pending <= 3'd2);

  assign m_valid = (occ != 2'd0);
  assign m_data  = w_head;
  assign w_xfer  = m_valid && m_ready;

  // Capture runs in every state so data read just before leaving RUN is
  // still delivered.
  stream_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (infl_q),
    .pop_i  (w_xfer),
    .data_i (fifo_dout),
    .data_o (w_head),
    .occ_o  (occ)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ((occ != 2'd0) || infl_q) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (enable)                          state_d = ST_RUN;
        else if ((occ == 2'd0) && !infl_q)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idle_q     <= 1'b1;
      infl_q     <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
      infl_q  <= fifo_rd_en;
      if (w_xfer) begin
        xfer_cnt_q <= xfer_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign idle     = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fifo_rd_stream                                               |
// | Purpose : Scoreboard bench for fifo_rd_stream with a behavioural FIFO.    |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        m_ready = 1'b0;
  logic        fifo_rd_en, m_valid, idle;
  logic [7:0]  m_data;
  logic [15:0] xfer_cnt;
  logic        fifo_rd_en_w, m_valid_w, idle_w;
  logic [7:0]  m_data_w;
  logic [3:0]  xfer_cnt_w;

  always #5 clk = ~clk;

  fifo_rd_stream dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .xfer_cnt(xfer_cnt), .idle(idle)
  );

  fifo_rd_stream #(.DATA_W(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en_w), .m_data(m_data_w),
    .m_valid(m_valid_w), .m_ready(m_ready), .xfer_cnt(xfer_cnt_w), .idle(idle_w)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         tx_cnt = 0;
  int         rd_cnt = 0;
  int         first_rd = -1;
  int         first_v = -1;
  int         base = 0;
  logic       rd_seen = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         xcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: observe at the falling edge, then advance the FIFO model
  // just after the rising edge so read data is stable for the whole next cycle.
  task automatic tick();
    @(negedge clk);
    rd_seen = fifo_rd_en;
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      chk("rd_while_empty", 32'(fifo_empty), 32'd0);
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid === 1'b1 && first_v < 0) first_v = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen === 1'b1 && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n;
    n = 0;
    while (tx_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("tx_timeout", 32'(tx_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    rst = 1'b1;
    tick();
  endtask

  task automatic load(input logic [7:0] first, input int n, input int n_exp);
    for (int i = 0; i < n; i++) begin
      fq.push_back(first + 8'(i));
      if (i < n_exp) exp_q.push_back(first + 8'(i));
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold stability.
  initial begin
    logic       stall;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== stall_data) begin
            errors++;
            $display("FAIL hold: m_valid=%b m_data=%h, expected 1/%h", m_valid, m_data, stall_data);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_extra: got %h, expected no transfer", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              errors++;
              $display("FAIL stream_data: got %h, expected %h", m_data, e);
            end
          end
          tx_cnt++;
          xcyc.push_back(cyc);
        end
        stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        stall_data = m_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b1;
    tick();

    // Single byte latency
    first_rd = -1;
    first_v = -1;
    rd_cnt = 0;
    base = tx_cnt;
    load(8'hA5, 1, 1);
    enable = 1'b1;
    m_ready = 1'b1;
    wait_tx(base + 1, 20);
    repeat (3) tick();
    chk("single_latency", 32'(first_v - first_rd), 32'd2);
    chk("single_reads", 32'(rd_cnt), 32'd1);
    chk("single_cnt", 32'(xfer_cnt), 32'd1);

    // Streaming 0x00..0x0F at full rate, then counter wrap on CNT_W=4
    do_reset();
    base = tx_cnt;
    load(8'h00, 16, 16);
    enable = 1'b1;
    m_ready = 1'b1;
    wait_tx(base + 16, 60);
    repeat (2) tick();
    chk("stream_cnt", 32'(xfer_cnt), 32'd16);
    chk("wrap_16", 32'(xfer_cnt_w), 32'd0);
    if (xcyc.size() >= base + 16) chk("stream_rate", 32'(xcyc[base+15] - xcyc[base]), 32'd15);
    load(8'h3C, 1, 1);
    wait_tx(base + 17, 20);
    repeat (2) tick();
    chk("wrap_17", 32'(xfer_cnt_w), 32'd1);
    chk("cnt_17", 32'(xfer_cnt), 32'd17);

    // Backpressure with a full FIFO
    do_reset();
    rd_cnt = 0;
    base = tx_cnt;
    load(8'h10, 16, 16);
    enable = 1'b1;
    m_ready = 1'b0;
    repeat (10) tick();
    chk("bp_reads", 32'(rd_cnt), 32'd3);
    chk("bp_occ", 32'(dut.occ), 32'd3);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    wait_tx(base + 16, 80);
    repeat (3) tick();
    chk("bp_cnt", 32'(xfer_cnt), 32'd16);
    chk("bp_reads_all", 32'(rd_cnt), 32'd16);

    // Reset mid-stream with two entries buffered
    m_ready = 1'b0;
    rd_cnt = 0;
    load(8'h80, 8, 8);
    n = 0;
    while (rd_cnt < 3 && n < 20) begin tick(); n++; end
    chk("mid_occ", 32'(dut.occ), 32'd2);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    enable = 1'b0;
    m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_cnt", 32'(xfer_cnt), 32'd0);

    // Drain: drop enable with occ=2 and one read in flight
    do_reset();
    rd_cnt = 0;
    base = tx_cnt;
    load(8'h40, 5, 3);
    enable = 1'b1;
    m_ready = 1'b0;
    n = 0;
    while (rd_cnt < 3 && n < 20) begin tick(); n++; end
    chk("drain_occ", 32'(dut.occ), 32'd2);
    chk("drain_infl", 32'(dut.infl_q), 32'd1);
    enable = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    n = 0;
    while (idle !== 1'b1 && n < 20) begin tick(); n++; end
    repeat (2) tick();
    chk("drain_reads", 32'(rd_cnt), 32'd3);
    chk("drain_tx", 32'(tx_cnt - base), 32'd3);
    chk("drain_idle", 32'(idle), 32'd1);
    chk("drain_cnt", 32'(xfer_cnt), 32'd3);
    chk("drain_fifo_left", 32'(fq.size()), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of FIFO read data and stream data.
REQ-002 SHALL have parameter CNT_W, default 16: width of the delivered-byte counter.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  high permits new FIFO reads; low stops new reads.
REQ-006 SHALL have port fifo_empty  input  1  empty flag from the upstream 16x8 FIFO.
REQ-007 SHALL have port fifo_dout  input  DATA_W  FIFO read data, valid the cycle after an accepted rd_en.
REQ-008 SHALL have port fifo_rd_en  output  1  read request to the FIFO.
REQ-009 SHALL have port m_data  output  DATA_W  stream data, head of internal buffer.
REQ-010 SHALL have port m_valid  output  1  stream data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-012 SHALL have port xfer_cnt  output  CNT_W  count of bytes delivered on the stream.
REQ-013 SHALL have port idle  output  1  high when FSM is in IDLE.

Function
REQ-014 SHALL hold a 3-entry in-order buffer with occupancy occ (0..3) and a 1-bit in-flight flag infl.
REQ-015 SHALL drive fifo_rd_en = (state==RUN) && !fifo_empty && (occ + infl <= 2); combinational from registered state and fifo_empty only, never from m_ready.
REQ-016 SHALL set infl at the edge ending any cycle with fifo_rd_en high, clear it otherwise.
REQ-017 SHALL, at the edge ending a cycle with infl high, write fifo_dout into buffer tail.
REQ-018 SHALL drive m_valid = (occ != 0) and m_data = buffer head; a transfer occurs when m_valid && m_ready.
REQ-019 SHALL handle capture and transfer in the same cycle: occ unchanged, head advances, tail written; order preserved.
REQ-020 SHALL give latency: fifo_rd_en in cycle N -> m_valid earliest in cycle N+2.
REQ-021 SHALL sustain 1 byte/cycle once primed with m_ready held high and FIFO non-empty.
REQ-022 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-023 SHALL never overflow the buffer (occ <= 3) nor read an empty FIFO.
REQ-024 SHALL increment xfer_cnt by 1 per transfer, wrapping modulo 2^CNT_W.
REQ-025 SHALL implement FSM IDLE/RUN/DRAIN:
 - IDLE->RUN when enable=1.
 - RUN->DRAIN when enable=0 and (occ!=0 or infl=1).
 - RUN->IDLE when enable=0 and occ=0 and infl=0.
 - DRAIN->RUN when enable=1.
 - DRAIN->IDLE when occ=0 and infl=0 (after the last transfer edge).
REQ-026 SHALL still capture in-flight data and deliver buffered data in DRAIN; no new reads there.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, occ=0, infl=0, xfer_cnt=0, m_data=0, m_valid=0, fifo_rd_en=0, idle=1.
REQ-028 SHALL discard buffered and in-flight data on reset mid-operation; no capture on the first edge after release.

Structure
REQ-029 SHALL place DATA_W/CNT_W defaults, buffer depth constant 3 and the FSM state encoding in a shared package fifo_rd_pkg.
REQ-030 SHALL implement the 3-entry buffer as sub-module stream_skid_buf (push, pop, data in/out, occ out).

Verification
REQ-031 Reset: rst=0 mid-stream with occ=2 -> next cycle m_valid=0, xfer_cnt=0, idle=1.
REQ-032 Single byte: FIFO holds 0xA5, enable=1, m_ready=1 -> fifo_rd_en one cycle (N), m_valid with m_data=0xA5 in N+2, xfer_cnt=1.
REQ-033 Streaming: 16 bytes 0x00..0x0F, m_ready=1 -> output 0x00..0x0F in order, one per cycle after priming, xfer_cnt=16.
REQ-034 Backpressure: m_ready=0 for 10 cycles with FIFO full -> exactly 3 reads issued, occ=3, m_data stable; release -> all 16 bytes in order.
REQ-035 Drain: enable=0 while occ=2, infl=1 -> no further fifo_rd_en, 3 bytes delivered, then idle=1.
REQ-036 Counter wrap: CNT_W=4, 17 transfers -> xfer_cnt=1.
